// File: rtl/ping_pong_sp_ram_pkg.sv
// Shared types and default sizing for the ping-pong sample store.
package ping_pong_sp_ram_pkg;

   localparam int unsigned DATA_WIDTH_DEF      = 16;
   localparam int unsigned SAMPLES_PER_BUF_DEF = 256;

   typedef enum logic {
      BUF_A = 1'b0,
      BUF_B = 1'b1
   } buf_id_e;

   function automatic buf_id_e other_buf(input buf_id_e b);
      return (b == BUF_A) ? BUF_B : BUF_A;
   endfunction

endpackage

// File: rtl/sp_ram_bank.sv
// One single-port RAM bank: synchronous write, registered read data.
// Read data holds its last value when no read is issued.
module sp_ram_bank #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage array is intentionally left unreset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ping_pong_sp_ram.sv
// Double-buffered sample store: producer fills the active bank, consumer reads the other.
// Optional: define PINGPONG_SP_RAM_ZERO_IDLE_EN to force rd_data_o to zero while rd_valid_o is low.
module ping_pong_sp_ram
   import ping_pong_sp_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned SAMPLES_PER_BUF = SAMPLES_PER_BUF_DEF,
   parameter int unsigned ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  active_buf_o,
   output logic                  buf_ready_pulse_o,
   output logic                  buf_ready_id_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   buf_id_e               active_q, active_d;
   buf_id_e               ready_id_q, ready_id_d;
   buf_id_e               rd_sel_q, rd_sel_d;
   logic                  pulse_q, pulse_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  we_a, we_b, re_a, re_b;
   logic [ADDR_WIDTH-1:0] addr_a, addr_b;
   logic [DATA_WIDTH-1:0] rdata_a, rdata_b, rd_mux;

   // Write pointer, bank swap and read bookkeeping.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      active_d   = active_q;
      ready_id_d = ready_id_q;
      rd_sel_d   = rd_sel_q;
      pulse_d    = 1'b0;
      rd_valid_d = rd_en_i;
      if (rd_en_i) begin
         rd_sel_d = other_buf(active_q);
      end
      if (in_valid_i) begin
         if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d   = '0;
            active_d   = other_buf(active_q);
            ready_id_d = active_q;
            pulse_d    = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         active_q   <= BUF_A;
         ready_id_q <= BUF_A;
         rd_sel_q   <= BUF_A;
         pulse_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         active_q   <= active_d;
         ready_id_q <= ready_id_d;
         rd_sel_q   <= rd_sel_d;
         pulse_q    <= pulse_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Written and read banks are always distinct, so each port sees one access per cycle.
   assign we_a   = in_valid_i && (active_q == BUF_A);
   assign we_b   = in_valid_i && (active_q == BUF_B);
   assign re_a   = rd_en_i && (active_q == BUF_B);
   assign re_b   = rd_en_i && (active_q == BUF_A);
   assign addr_a = we_a ? wr_ptr_q : rd_addr_i;
   assign addr_b = we_b ? wr_ptr_q : rd_addr_i;

   sp_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SAMPLES_PER_BUF),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bank_a (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we_a),
      .re_i    (re_a),
      .addr_i  (addr_a),
      .wdata_i (in_data_i),
      .rdata_o (rdata_a)
   );

   sp_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SAMPLES_PER_BUF),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bank_b (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we_b),
      .re_i    (re_b),
      .addr_i  (addr_b),
      .wdata_i (in_data_i),
      .rdata_o (rdata_b)
   );

   assign rd_mux = (rd_sel_q == BUF_A) ? rdata_a : rdata_b;

`ifdef PINGPONG_SP_RAM_ZERO_IDLE_EN
   assign rd_data_o = rd_valid_q ? rd_mux : '0;
`else
   assign rd_data_o = rd_mux;
`endif

   assign rd_valid_o        = rd_valid_q;
   assign active_buf_o      = active_q;
   assign buf_ready_pulse_o = pulse_q;
   assign buf_ready_id_o    = ready_id_q;

endmodule

// File: tb/tb_ping_pong_sp_ram.sv
// Directed bench for ping_pong_sp_ram: table-driven reads plus fill/swap/reset sequences.
module tb_ping_pong_sp_ram;

   localparam int unsigned DW = 16;
   localparam int unsigned N  = 256;
   localparam int unsigned AW = 8;

   logic          clk_i      = 1'b0;
   logic          rst_ni     = 1'b0;
   logic          in_valid_i = 1'b0;
   logic [DW-1:0] in_data_i  = '0;
   logic          rd_en_i    = 1'b0;
   logic [AW-1:0] rd_addr_i  = '0;
   logic [DW-1:0] rd_data_o;
   logic          rd_valid_o;
   logic          active_buf_o;
   logic          buf_ready_pulse_o;
   logic          buf_ready_id_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          rd_en;
      logic [AW-1:0] addr;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   ping_pong_sp_ram dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .in_valid_i        (in_valid_i),
      .in_data_i         (in_data_i),
      .rd_en_i           (rd_en_i),
      .rd_addr_i         (rd_addr_i),
      .rd_data_o         (rd_data_o),
      .rd_valid_o        (rd_valid_o),
      .active_buf_o      (active_buf_o),
      .buf_ready_pulse_o (buf_ready_pulse_o),
      .buf_ready_id_o    (buf_ready_id_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [DW-1:0] idle_data(input logic [DW-1:0] last);
`ifdef PINGPONG_SP_RAM_ZERO_IDLE_EN
      return '0;
`else
      return last;
`endif
   endfunction

   task automatic apply_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         rd_en_i   = vecs[i].rd_en;
         rd_addr_i = vecs[i].addr;
         step();
         chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid_o), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d rd_data", i), 32'(rd_data_o), 32'(vecs[i].exp_data));
      end
      rd_en_i = 1'b0;
   endtask

   // Write one full bank; optionally gappy and optionally reading the inactive bank each sample.
   task automatic fill(input logic [DW-1:0] base, input bit gappy, input bit rd_inactive,
                       input logic [DW-1:0] rd_base, input logic exp_active);
      int   stray    = 0;
      logic exp_next = ~exp_active;
      for (int i = 0; i < int'(N); i++) begin
         if (gappy && ((i % 3 == 2) || (i == int'(N) - 1))) begin
            in_valid_i = 1'b0;
            rd_en_i    = 1'b0;
            step();
            if (active_buf_o !== exp_active || buf_ready_pulse_o !== 1'b0) stray++;
         end
         in_valid_i = 1'b1;
         in_data_i  = base + DW'(i);
         if (rd_inactive) begin
            rd_en_i   = 1'b1;
            rd_addr_i = AW'(i);
         end
         step();
         if (rd_inactive) begin
            chk($sformatf("concurrent read %0d", i), {15'd0, rd_valid_o, rd_data_o},
                {15'd0, 1'b1, rd_base + DW'(i)});
         end
         if (i < int'(N) - 1 && (active_buf_o !== exp_active || buf_ready_pulse_o !== 1'b0)) stray++;
      end
      in_valid_i = 1'b0;
      rd_en_i    = 1'b0;
      chk("no early swap", 32'(stray), 32'd0);
      chk("swap active_buf", 32'(active_buf_o), 32'(exp_next));
      chk("ready pulse high", 32'(buf_ready_pulse_o), 32'd1);
      chk("ready id", 32'(buf_ready_id_o), 32'(exp_active));
      step();
      chk("ready pulse drop", 32'(buf_ready_pulse_o), 32'd0);
      chk("ready id held", 32'(buf_ready_id_o), 32'(exp_active));
   endtask

   initial begin
      vecs.push_back('{1'b1, 8'd0,   1'b1, 16'hA000});
      vecs.push_back('{1'b1, 8'd1,   1'b1, 16'hA001});
      vecs.push_back('{1'b1, 8'd2,   1'b1, 16'hA002});
      vecs.push_back('{1'b1, 8'd3,   1'b1, 16'hA003});
      vecs.push_back('{1'b1, 8'd4,   1'b1, 16'hA004});
      vecs.push_back('{1'b0, 8'd0,   1'b0, idle_data(16'hA004)});
      vecs.push_back('{1'b1, 8'd255, 1'b1, 16'hA0FF});
      vecs.push_back('{1'b0, 8'd9,   1'b0, idle_data(16'hA0FF)});
      vecs.push_back('{1'b1, 8'd0,   1'b1, 16'hB000});
      vecs.push_back('{1'b1, 8'd255, 1'b1, 16'hB0FF});
      vecs.push_back('{1'b1, 8'd128, 1'b1, 16'hB080});
      vecs.push_back('{1'b0, 8'd0,   1'b0, idle_data(16'hB080)});
      vecs.push_back('{1'b1, 8'd0,   1'b1, 16'h1000});
      vecs.push_back('{1'b1, 8'd99,  1'b1, 16'h1063});
      vecs.push_back('{1'b1, 8'd100, 1'b1, 16'h1064});
      vecs.push_back('{1'b1, 8'd255, 1'b1, 16'h10FF});

      // Reset state
      repeat (5) step();
      chk("reset active_buf", 32'(active_buf_o), 32'd0);
      chk("reset pulse", 32'(buf_ready_pulse_o), 32'd0);
      chk("reset rd_valid", 32'(rd_valid_o), 32'd0);
      chk("reset rd_data", 32'(rd_data_o), 32'd0);
      chk("reset ready id", 32'(buf_ready_id_o), 32'd0);
      rst_ni = 1'b1;
      step();

      // Bank A fill, then table reads of A
      fill(16'hA000, 1'b0, 1'b0, 16'h0000, 1'b0);
      apply_vecs(0, 7);

      // Bank B fill, then table reads of B
      fill(16'hB000, 1'b0, 1'b0, 16'h0000, 1'b1);
      apply_vecs(8, 11);

      // Refill A, then read A every sample while B fills with gaps
      fill(16'hC000, 1'b0, 1'b0, 16'h0000, 1'b0);
      fill(16'hD000, 1'b1, 1'b1, 16'hC000, 1'b1);

      // Partial fill of A (100 samples) with a read of B on the last one, then async reset
      for (int i = 0; i < 100; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = 16'hE000 + DW'(i);
         rd_en_i    = (i == 99);
         rd_addr_i  = 8'd5;
         step();
      end
      in_valid_i = 1'b0;
      rd_en_i    = 1'b0;
      chk("pre-reset rd_valid", 32'(rd_valid_o), 32'd1);
      chk("pre-reset rd_data", 32'(rd_data_o), 32'h0000D005);
      chk("pre-reset ready id", 32'(buf_ready_id_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async reset active_buf", 32'(active_buf_o), 32'd0);
      chk("async reset rd_valid", 32'(rd_valid_o), 32'd0);
      chk("async reset rd_data", 32'(rd_data_o), 32'd0);
      chk("async reset pulse", 32'(buf_ready_pulse_o), 32'd0);
      chk("async reset ready id", 32'(buf_ready_id_o), 32'd0);
      repeat (2) step();
      rst_ni = 1'b1;
      step();

      // Refill must restart at bank A address 0 and swap after exactly 256 samples
      fill(16'h1000, 1'b0, 1'b0, 16'h0000, 1'b0);
      apply_vecs(12, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
